// File: rtl/fdc_pkg.sv
// Shared types and default sizes for the FDC edge-counter measurement stage.
package fdc_pkg;

    localparam int unsigned FDC_CNT_W       = 10;
    localparam int unsigned FDC_OUT_W       = 5;
    localparam int unsigned FDC_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } fdc_state_t;

endpackage

// File: rtl/fdc_sync_edge.sv
// Synchronizes one asynchronous pin and flags its rising edges.
// The whole chain freezes while ena is low so no sample is consumed during a freeze.
module fdc_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic din,
    output logic level,
    output logic rise_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else if (ena) begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level  = chain[STAGES-1];
    assign rise_c = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/fdc_edge_counter.sv
// Counts VCO rising edges per reference-clock period and latches the count.
// Optional saturation with overflow flag when FDC_SAT_EN is defined.
module fdc_edge_counter
    import fdc_pkg::*;
#(
    parameter int unsigned CNT_W       = FDC_CNT_W,
    parameter int unsigned OUT_W       = FDC_OUT_W,
    parameter int unsigned SYNC_STAGES = FDC_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             vco_in,
    input  logic             ref_in,
    input  logic             selec,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             ovf
);

    logic vco_rise_c;
    logic ref_rise_c;
    logic vco_level;
    logic ref_level;
    logic unused_levels;

    fdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vco (
        .clk    (clk),
        .reset  (reset),
        .ena    (ena),
        .din    (vco_in),
        .level  (vco_level),
        .rise_c (vco_rise_c)
    );

    fdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ref (
        .clk    (clk),
        .reset  (reset),
        .ena    (ena),
        .din    (ref_in),
        .level  (ref_level),
        .rise_c (ref_rise_c)
    );

    assign unused_levels = vco_level ^ ref_level;

    fdc_state_t       state;
    fdc_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] result_next;
    logic             valid_q;
    logic             valid_next;
`ifdef FDC_SAT_EN
    logic             sticky;
    logic             sticky_next;
    logic             ovf_q;
    logic             ovf_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // A vco rise coincident with a ref rise is counted into the new window.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        result_next = result;
        valid_next  = 1'b0;
`ifdef FDC_SAT_EN
        sticky_next = sticky;
        ovf_next    = ovf_q;
`endif
        case (state)
            IDLE: begin
                if (ref_rise_c) begin
                    state_next = COUNT;
                    cnt_next   = '0;
                end
            end
            COUNT: begin
                if (ref_rise_c) begin
                    result_next = cnt;
                    cnt_next    = CNT_W'(vco_rise_c);
                    valid_next  = 1'b1;
`ifdef FDC_SAT_EN
                    ovf_next    = sticky;
                    sticky_next = 1'b0;
`endif
                end else if (vco_rise_c) begin
`ifdef FDC_SAT_EN
                    if (&cnt) begin
                        sticky_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
`else
                    cnt_next = cnt + CNT_W'(1);
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // valid_q is held during a freeze so a pending result still pulses on resume.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            result  <= '0;
            valid_q <= 1'b0;
`ifdef FDC_SAT_EN
            sticky  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else if (ena) begin
            cnt     <= cnt_next;
            result  <= result_next;
            valid_q <= valid_next;
`ifdef FDC_SAT_EN
            sticky  <= sticky_next;
            ovf_q   <= ovf_next;
`endif
        end
    end

    assign valid = valid_q & ena;
    assign out   = selec ? OUT_W'(result >> OUT_W) : result[OUT_W-1:0];

`ifdef FDC_SAT_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fdc_edge_counter.sv
// Randomized bench for fdc_edge_counter against a window-counting reference model.
module tb_fdc_edge_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       vco_in;
    logic       ref_in;
    logic       selec;
    logic [4:0] out;
    logic       valid;
    logic       ovf;

    always #5 clk = ~clk;

    fdc_edge_counter dut (
        .clk    (clk),
        .reset  (reset),
        .ena    (ena),
        .vco_in (vco_in),
        .ref_in (ref_in),
        .selec  (selec),
        .out    (out),
        .valid  (valid),
        .ovf    (ovf)
    );

`ifdef FDC_SAT_EN
    localparam int LONG_EXP = 1023;
`else
    localparam int LONG_EXP = 976;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] slice_of(input int r, input logic s);
        return s ? 5'((r >> 5) & 31) : 5'(r & 31);
    endfunction

    // Reference model: counts rises in the stream of pin samples taken on enabled cycles.
    bit  started = 1'b0;
    bit  pv, pr, armed;
    int  mcnt;
    int  exp_q[$];
    bit  ovf_q[$];
    int  cur_exp;
    bit  cur_ovf;
    int  const_exp  = -1;
    int  const_skip = 0;
    int  n_valid    = 0;

    always @(posedge clk) begin
        if (reset) begin
            pv = 1'b0; pr = 1'b0; armed = 1'b0; mcnt = 0;
            exp_q.delete(); ovf_q.delete();
            cur_exp = 0; cur_ovf = 1'b0;
        end else if (ena) begin
            bit vr, rr;
            vr = vco_in && !pv;
            rr = ref_in && !pr;
            pv = vco_in;
            pr = ref_in;
            if (rr) begin
                if (armed) begin
`ifdef FDC_SAT_EN
                    exp_q.push_back(mcnt > 1023 ? 1023 : mcnt);
                    ovf_q.push_back(mcnt > 1023);
`else
                    exp_q.push_back(mcnt % 1024);
                    ovf_q.push_back(1'b0);
`endif
                    mcnt = vr ? 1 : 0;
                end else begin
                    armed = 1'b1;
                    mcnt  = 0;
                end
            end else if (armed && vr) begin
                mcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (ena) begin
                if (valid === 1'b1) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 32'(valid), 32'(0));
                    end else begin
                        cur_exp = exp_q.pop_front();
                        cur_ovf = ovf_q.pop_front();
                        if (const_skip > 0) const_skip--;
                        else if (const_exp >= 0)
                            check("spec_value", 32'(out), 32'(slice_of(const_exp, selec)));
                    end
                end
                check("out", 32'(out), 32'(slice_of(cur_exp, selec)));
                check("ovf", 32'(ovf), 32'(cur_ovf));
            end else begin
                check("valid_frozen", 32'(valid), 32'(0));
            end
        end
    end

    int vph = 0;
    int rph = 0;

    task automatic run_phase(input int vp, input int rp, input bit aligned, input int ncyc,
                             input int cexp, input bit rnd_ena,
                             input int rst_at, input int off_at, input int off_len);
        int off_cnt = 0;
        if (aligned) begin
            vph = 0; rph = 0;
        end else begin
            vph = $urandom_range(0, vp - 1);
            rph = $urandom_range(0, rp - 1);
        end
        const_exp  = cexp;
        const_skip = 2;
        for (int i = 0; i < ncyc; i++) begin
            reset = (i == rst_at);
            if (i >= off_at && i < off_at + off_len) begin
                ena = 1'b0;
            end else if (rnd_ena && off_cnt > 0) begin
                off_cnt--;
                ena = 1'b0;
            end else begin
                ena = 1'b1;
                if (rnd_ena && $urandom_range(0, 63) == 0) off_cnt = $urandom_range(1, 10);
            end
            vco_in = (vph < vp / 2);
            ref_in = (rph < rp / 2);
            selec  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
            vph = (vph + 1) % vp;
            rph = (rph + 1) % rp;
        end
    endtask

    initial begin
        reset = 1'b1; ena = 1'b1; vco_in = 1'b0; ref_in = 1'b0; selec = 1'b0;
        // Reset held for 3 clocks while the inputs toggle.
        for (int i = 0; i < 3; i++) begin
            vco_in = ~vco_in;
            ref_in = 1'($urandom_range(0, 1));
            selec  = ~selec;
            @(posedge clk);
            #2;
            started = 1'b1;
        end
        run_phase(8,    160,  1'b0, 160 * 6,   20,       1'b0, -1, -1, 0);
        run_phase(4,    2400, 1'b0, 2400 * 4,  600,      1'b0, -1, -1, 0);
        run_phase(4,    8000, 1'b0, 8000 * 4,  LONG_EXP, 1'b0, -1, -1, 0);
        run_phase(4,    1600, 1'b0, 1600 * 5,  400,      1'b0, -1, -1, 0);
        run_phase(8,    160,  1'b1, 160 * 7,   20,       1'b0, -1, -1, 0);
        run_phase(8,    160,  1'b1, 160 * 8,   -1,       1'b0, 160 * 3 + 80, 160 * 5 + 40, 50);
        for (int k = 0; k < 4; k++) begin
            int vp, rp;
            vp = $urandom_range(4, 12);
            rp = $urandom_range(60, 300);
            run_phase(vp, rp, 1'b0, rp * 6, -1, 1'b1, -1, -1, 0);
        end
        // Drain: ref held low so every window already closed gets reported.
        reset = 1'b0; ena = 1'b1; ref_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            vco_in = ~vco_in;
            selec  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
        check("pending_results", 32'(exp_q.size()), 32'(0));
        check("enough_valids", 32'(n_valid > 20), 32'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
